slave_memory_pipe: RTL and testbench

SLAVE_MEMORY_PIPE -- requirements
Module: slave_memory_pipe

---
 rtl/slave_memory_pipe_if.sv | 30 +++
 rtl/slave_memory_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_slave_memory_pipe.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_memory_pipe_if.sv
// slave_memory_pipe_if: request/response bundle of the pipelined slave memory.
// The master side issues writes and read bursts. The slave side answers with
// ready, read beats and error pulses.
interface slave_memory_pipe_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int BURST_WIDTH = 4
) ();
  logic                   wen;
  logic                   ren;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  wdata;
  logic [BURST_WIDTH-1:0] rlen;
  logic                   ready;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   rvalid;
  logic                   rlast;
  logic                   err;
  logic                   perr;

  modport master (
    output wen, ren, addr, wdata, rlen,
    input  ready, rdata, rvalid, rlast, err, perr
  );

  modport slave (
    input  wen, ren, addr, wdata, rlen,
    output ready, rdata, rvalid, rlast, err, perr
  );
endinterface

// File: rtl/slave_memory_pipe.sv
// slave_memory_pipe: word memory with single writes, incrementing read bursts
// that wrap at the top of memory, and a RD_LATENCY-deep read pipeline.
// Defining SLAVE_MEM_PARITY_EN adds one even-parity bit per stored word. That
// bit is checked on every read beat and reported on perr.
module slave_memory_pipe #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_SIZE    = 4096,
  parameter int RD_LATENCY  = 2,
  parameter int BURST_WIDTH = 4
) (
  input logic                clk,
  input logic                rstn,
  slave_memory_pipe_if.slave bus
);

`ifdef SLAVE_MEM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif
  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0]    MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] RLEN_ZERO = {BURST_WIDTH{1'b0}};
  localparam logic [BURST_WIDTH-1:0] RLEN_ONE  = BURST_WIDTH'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                 state_r, state_s;
  logic [ADDR_WIDTH-1:0]  next_addr_r, next_addr_s;
  logic [BURST_WIDTH-1:0] left_r, left_s;
  logic                   err_r, err_s;
  logic                   addr_ok_s;
  logic                   wr_s;
  logic                   issue_s;
  logic                   issue_last_s;
  logic [ADDR_WIDTH-1:0]  issue_addr_s;
  logic [WORD_W-1:0]      wr_word_s;
  logic [WORD_W-1:0]      rd_word_s;

  logic [WORD_W-1:0]      mem_r [MEM_SIZE];
  logic [RD_LATENCY-1:0]  pipe_valid_r;
  logic [RD_LATENCY-1:0]  pipe_last_r;
  logic [DATA_WIDTH-1:0]  pipe_data_r [RD_LATENCY];

  // Next word address of a burst, wrapping from the last word back to 0.
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    if (a == LAST_ADDR) begin
      return {ADDR_WIDTH{1'b0}};
    end else begin
      return a + ADDR_ONE;
    end
  endfunction

  // Word index into the storage array; only called with in-range addresses.
  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0];
  endfunction

`ifdef SLAVE_MEM_PARITY_EN
  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  assign wr_word_s = {even_parity(bus.wdata), bus.wdata};
`else
  assign wr_word_s = bus.wdata;
`endif

  assign addr_ok_s = ({1'b0, bus.addr} < MEM_LIMIT);
  assign rd_word_s = mem_r[to_idx(issue_addr_s)];

  // Control state, burst address/beat counter and the error pulse register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      next_addr_r <= {ADDR_WIDTH{1'b0}};
      left_r      <= RLEN_ZERO;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      next_addr_r <= next_addr_s;
      left_r      <= left_s;
      err_r       <= err_s;
    end
  end

  // Request decode. Beat issue and next state of the IDLE/BURST controller.
  always_comb begin
    state_s      = state_r;
    next_addr_s  = next_addr_r;
    left_s       = left_r;
    wr_s         = 1'b0;
    issue_s      = 1'b0;
    issue_last_s = 1'b0;
    issue_addr_s = bus.addr;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (addr_ok_s) begin
          wr_s    = bus.wen;
          issue_s = bus.ren;
        end else begin
          err_s   = bus.wen | bus.ren;
        end
        if (issue_s) begin
          issue_last_s = (bus.rlen == RLEN_ZERO);
          next_addr_s  = wrap_inc(bus.addr);
          left_s       = bus.rlen;
          if (bus.rlen == RLEN_ZERO) begin
            state_s = IDLE;
          end else begin
            state_s = BURST;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        // New requests are not accepted mid-burst; flag them instead.
        err_s        = bus.wen | bus.ren;
        issue_s      = 1'b1;
        issue_addr_s = next_addr_r;
        issue_last_s = (left_r == RLEN_ONE);
        next_addr_s  = wrap_inc(next_addr_r);
        left_s       = left_r - RLEN_ONE;
        if (left_r == RLEN_ONE) begin
          state_s = IDLE;
        end else begin
          state_s = BURST;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Storage array. Non-blocking update gives read-first behaviour on a
  // same-address read and write. Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[to_idx(bus.addr)] <= wr_word_s;
    end
  end

  // Read pipeline. Data stages only load on a valid beat, so rdata holds
  // its last value while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_valid_r <= {RD_LATENCY{1'b0}};
      pipe_last_r  <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      pipe_valid_r[0] <= issue_s;
      pipe_last_r[0]  <= issue_s & issue_last_s;
      if (issue_s) begin
        pipe_data_r[0] <= rd_word_s[DATA_WIDTH-1:0];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_last_r[i]  <= pipe_last_r[i-1];
        if (pipe_valid_r[i-1]) begin
          pipe_data_r[i] <= pipe_data_r[i-1];
        end
      end
    end
  end

`ifdef SLAVE_MEM_PARITY_EN
  logic [RD_LATENCY-1:0] pipe_perr_r;

  // Parity check result travels with its beat through the read pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe_perr_r <= {RD_LATENCY{1'b0}};
    end else begin
      pipe_perr_r[0] <= issue_s & (^rd_word_s);
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_perr_r[i] <= pipe_perr_r[i-1];
      end
    end
  end

  assign bus.perr = pipe_perr_r[RD_LATENCY-1];
`else
  assign bus.perr = 1'b0;
`endif

  assign bus.ready  = (state_r == IDLE);
  assign bus.rdata  = pipe_data_r[RD_LATENCY-1];
  assign bus.rvalid = pipe_valid_r[RD_LATENCY-1];
  assign bus.rlast  = pipe_last_r[RD_LATENCY-1];
  assign bus.err    = err_r;

endmodule

// File: tb/tb_slave_memory_pipe.sv
// tb_slave_memory_pipe: directed and random stimulus for slave_memory_pipe.
// The default-size instance is checked every cycle against a transaction-level
// model. A second instance with MEM_SIZE=2048 covers the out-of-range and
// wrap cases.
module tb_slave_memory_pipe;
  localparam int MEM   = 4096;
  localparam int SMEM  = 2048;
  localparam int RDL   = 2;

  logic clk;
  logic rstn;
  int   passed = 0;
  int   total  = 0;
  int   e      = 0;
  int   busy_end = 0;

  logic [7:0] ref_mem [MEM];
  bit         ref_bad [MEM];
  logic [7:0] exp_data [int];
  bit         exp_last [int];
  bit         exp_perr [int];
  bit         err_at   [int];
  logic [7:0] model_rdata;

  slave_memory_pipe_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .BURST_WIDTH(4)) bus ();
  slave_memory_pipe_if #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .BURST_WIDTH(4)) sbus ();

  slave_memory_pipe #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_SIZE(MEM),
                      .RD_LATENCY(RDL), .BURST_WIDTH(4))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  slave_memory_pipe #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_SIZE(SMEM),
                      .RD_LATENCY(RDL), .BURST_WIDTH(4))
    sdut (.clk(clk), .rstn(rstn), .bus(sbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, expv);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, " ready"},  32'(bus.ready),  32'd1);
    chk({tag, " rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({tag, " rlast"},  32'(bus.rlast),  32'd0);
    chk({tag, " err"},    32'(bus.err),    32'd0);
    chk({tag, " perr"},   32'(bus.perr),   32'd0);
    chk({tag, " rdata"},  32'(bus.rdata),  32'd0);
  endtask

  task automatic model_reset();
    exp_data.delete();
    exp_last.delete();
    exp_perr.delete();
    err_at.delete();
    busy_end    = e;
    model_rdata = 8'h00;
  endtask

  // Transaction-level view of one request presented at edge k.
  task automatic model_edge(input int k, input logic w, input logic r,
                            input logic [11:0] a, input logic [7:0] wd,
                            input logic [3:0] rl);
    bit idle;
    int n;
    int ad;
    idle = (k > busy_end);
    n    = int'(rl);
    if ((w || r) && (!idle || int'(a) >= MEM)) err_at[k] = 1'b1;
    if (idle && int'(a) < MEM) begin
      if (r) begin
        for (int j = 0; j <= n; j++) begin
          ad = (int'(a) + j) % MEM;
          exp_data[k + j + RDL - 1] = ref_mem[ad];
          exp_last[k + j + RDL - 1] = (j == n);
          exp_perr[k + j + RDL - 1] = ref_bad[ad];
        end
        busy_end = k + n;
      end
      if (w) begin
        ref_mem[a] = wd;
        ref_bad[a] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    bit v;
    v = exp_data.exists(e);
    if (v) model_rdata = exp_data[e];
    chk("rvalid", 32'(bus.rvalid), 32'(v));
    chk("rlast",  32'(bus.rlast),  v ? 32'(exp_last[e]) : 32'd0);
    chk("perr",   32'(bus.perr),   v ? 32'(exp_perr[e]) : 32'd0);
    chk("rdata",  32'(bus.rdata),  32'(model_rdata));
    chk("err",    32'(bus.err),    32'(err_at.exists(e)));
    chk("ready",  32'(bus.ready),  32'(e >= busy_end));
  endtask

  task automatic cyc(input logic w, input logic r, input logic [11:0] a,
                     input logic [7:0] wd, input logic [3:0] rl);
    int k;
    bus.wen = w; bus.ren = r; bus.addr = a; bus.wdata = wd; bus.rlen = rl;
    k = e + 1;
    model_edge(k, w, r, a, wd, rl);
    @(posedge clk); #1;
    e = k;
    check_outputs();
    bus.wen = 1'b0; bus.ren = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 12'h000, 8'h00, 4'h0);
  endtask

  task automatic scyc(input logic w, input logic r, input logic [11:0] a,
                      input logic [7:0] wd, input logic [3:0] rl);
    sbus.wen = w; sbus.ren = r; sbus.addr = a; sbus.wdata = wd; sbus.rlen = rl;
    @(posedge clk); #1;
    e++;
    sbus.wen = 1'b0; sbus.ren = 1'b0;
  endtask

  initial begin
    logic       w, r;
    logic [11:0] a;
    logic [7:0]  wd;
    logic [3:0]  rl;

    rstn = 1'b1;
    bus.wen = 1'b0;  bus.ren = 1'b0;  bus.addr = 12'h000;  bus.wdata = 8'h00;  bus.rlen = 4'h0;
    sbus.wen = 1'b0; sbus.ren = 1'b0; sbus.addr = 12'h000; sbus.wdata = 8'h00; sbus.rlen = 4'h0;
    #3 rstn = 1'b0;
    #1 rst_chk("reset");
    chk("small reset ready",  32'(sbus.ready),  32'd1);
    chk("small reset rvalid", 32'(sbus.rvalid), 32'd0);
    #8 rstn = 1'b1;
    model_reset();

    // Small instance: out-of-range drops, wrap at 0x7FF, request during burst.
    scyc(1'b1, 1'b0, 12'h100, 8'h5A, 4'h0);
    chk("small in-range write err", 32'(sbus.err), 32'd0);
    scyc(1'b1, 1'b0, 12'h7FF, 8'h77, 4'h0);
    scyc(1'b1, 1'b0, 12'h000, 8'h88, 4'h0);
    scyc(1'b1, 1'b0, 12'h900, 8'hC3, 4'h0);
    chk("oob write err", 32'(sbus.err), 32'd1);
    scyc(1'b0, 1'b1, 12'h900, 8'h00, 4'h3);
    chk("oob read err",    32'(sbus.err),    32'd1);
    chk("oob read ready",  32'(sbus.ready),  32'd1);
    scyc(1'b0, 1'b0, 12'h000, 8'h00, 4'h0);
    chk("oob err one cycle", 32'(sbus.err),    32'd0);
    chk("oob read no beat",  32'(sbus.rvalid), 32'd0);
    scyc(1'b0, 1'b1, 12'h100, 8'h00, 4'h0);
    scyc(1'b0, 1'b0, 12'h000, 8'h00, 4'h0);
    chk("alias untouched valid", 32'(sbus.rvalid), 32'd1);
    chk("alias untouched data",  32'(sbus.rdata),  32'h5A);
    scyc(1'b0, 1'b1, 12'h7FF, 8'h00, 4'h1);
    chk("small burst ready", 32'(sbus.ready), 32'd0);
    scyc(1'b1, 1'b0, 12'h100, 8'hEE, 4'h0);
    chk("write in burst err", 32'(sbus.err),    32'd1);
    chk("wrap beat0 data",    32'(sbus.rdata),  32'h77);
    chk("wrap beat0 last",    32'(sbus.rlast),  32'd0);
    scyc(1'b0, 1'b0, 12'h000, 8'h00, 4'h0);
    chk("wrap beat1 data",    32'(sbus.rdata),  32'h88);
    chk("wrap beat1 last",    32'(sbus.rlast),  32'd1);
    chk("burst err one cycle", 32'(sbus.err),   32'd0);
    scyc(1'b0, 1'b1, 12'h100, 8'h00, 4'h0);
    scyc(1'b0, 1'b0, 12'h000, 8'h00, 4'h0);
    chk("burst write dropped", 32'(sbus.rdata), 32'h5A);
    busy_end = e;

    // Preload every word of the default instance.
    for (int i = 0; i < MEM; i++) begin
      cyc(1'b1, 1'b0, 12'(i), 8'($urandom_range(0, 255)), 4'h0);
    end

    // Single-beat read with two-cycle latency.
    cyc(1'b1, 1'b0, 12'h010, 8'hA5, 4'h0);
    cyc(1'b0, 1'b1, 12'h010, 8'h00, 4'h0);
    chk("single read not yet", 32'(bus.rvalid), 32'd0);
    idle_cyc();
    chk("single read data", 32'(bus.rdata), 32'hA5);
    chk("single read last", 32'(bus.rlast), 32'd1);

    // Burst wrapping from 0xFFF to 0x000.
    cyc(1'b1, 1'b0, 12'hFFE, 8'h11, 4'h0);
    cyc(1'b1, 1'b0, 12'hFFF, 8'h22, 4'h0);
    cyc(1'b1, 1'b0, 12'h000, 8'h33, 4'h0);
    cyc(1'b0, 1'b1, 12'hFFE, 8'h00, 4'h2);
    chk("wrap ready low 1", 32'(bus.ready), 32'd0);
    idle_cyc();
    chk("wrap ready low 2", 32'(bus.ready), 32'd0);
    chk("wrap beat 0x11",   32'(bus.rdata), 32'h11);
    idle_cyc();
    chk("wrap ready back",  32'(bus.ready), 32'd1);
    chk("wrap beat 0x22",   32'(bus.rdata), 32'h22);
    idle_cyc();
    chk("wrap beat 0x33",   32'(bus.rdata), 32'h33);
    chk("wrap rlast",       32'(bus.rlast), 32'd1);

    // Simultaneous write and read on one address returns the old word.
    cyc(1'b1, 1'b0, 12'h020, 8'h01, 4'h0);
    cyc(1'b1, 1'b1, 12'h020, 8'h02, 4'h0);
    idle_cyc();
    chk("read-first old", 32'(bus.rdata), 32'h01);
    cyc(1'b0, 1'b1, 12'h020, 8'h00, 4'h0);
    idle_cyc();
    chk("read-first new", 32'(bus.rdata), 32'h02);

    // Reset while beat 2 of an 8-beat burst is on the outputs.
    cyc(1'b0, 1'b1, 12'h040, 8'h00, 4'h7);
    idle_cyc();
    idle_cyc();
    idle_cyc();
    chk("beat2 valid before reset", 32'(bus.rvalid), 32'd1);
    #2 rstn = 1'b0;
    #1 rst_chk("mid-burst reset");
    model_reset();
    #2 rstn = 1'b1;
    cyc(1'b0, 1'b1, 12'h010, 8'h00, 4'h0);
    for (int i = 0; i < 10; i++) idle_cyc();

`ifdef SLAVE_MEM_PARITY_EN
    // Corrupt the stored parity bit of word 0x005 and read it back.
    dut.mem_r[5][8] = ~dut.mem_r[5][8];
    ref_bad[5] = 1'b1;
    cyc(1'b0, 1'b1, 12'h005, 8'h00, 4'h0);
    idle_cyc();
    chk("parity flip perr", 32'(bus.perr), 32'd1);
`endif

    // Back-to-back bursts issued as soon as ready returns.
    for (int i = 0; i < 40; i++) begin
      r = bus.ready;
      cyc(1'b0, r, 12'($urandom_range(0, MEM - 1)), 8'h00, 4'($urandom_range(0, 3)));
    end

    // Random mix of writes, reads and requests during bursts.
    for (int i = 0; i < 600; i++) begin
      w  = ($urandom_range(0, 99) < 30);
      r  = ($urandom_range(0, 99) < 35);
      a  = 12'($urandom_range(0, MEM - 1));
      wd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rl = 4'($urandom_range(0, 15));
      else rl = 4'($urandom_range(0, 3));
      cyc(w, r, a, wd, rl);
    end
    for (int i = 0; i < 20; i++) idle_cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
